div_seq_ctrl: RTL and testbench

Multi-cycle RV32M divide/remainder control stage that sits directly upstream of the combinational `divider_unsigned` core and consumes its quotient/remainder. It accepts an operation through a valid/ready handshake and converts signed operands to magnitudes. It holds the core inputs stable for a fixed settle window so the core is timed as a multicycle path. It then applies sign correction and presents the result through a second valid/ready handshake. Divide-by-zero and signed overflow are resolved without using the core.

---
 rtl/div_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// ---------------------------------------------------------------------------
// div_seq_ctrl
//
// Multi-cycle RV32M divide/remainder control stage wrapped around a purely
// combinational unsigned divider core (divider_unsigned, also in this file).
// An operation is accepted through a valid/ready handshake. Signed operands
// are converted to magnitudes and registered. The registered magnitudes then
// drive the core, unchanged, for WAIT_CYCLES cycles so the core can be timed
// as a multicycle path. After that window the quotient or remainder is
// sign-corrected and held on a second valid/ready handshake. Divide-by-zero
// and signed overflow are resolved on the accept cycle without the core.
//
// Optional feature macro: DIV_FAST_PATH_EN
//   When defined, operands with |rs2| > |rs1| bypass the core. The quotient
//   is 0 and the remainder is rs1, and the result is ready one cycle after
//   accept.
//
// Parameters:
//   XLEN        operand/result width (core is built with N = XLEN)
//   WAIT_CYCLES core settle cycles, 1..15
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous kill of any in-flight operation
//   in_valid   request valid
//   in_ready   high exactly when IDLE
//   op         00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1, rs2   dividend, divisor
//   in_tag     destination tag, passed through to out_tag
//   out_valid  result valid (state DONE)
//   out_ready  consumer accepts the result
//   result     final rd value
//   out_tag    tag belonging to result
//   busy       state is not IDLE
// ---------------------------------------------------------------------------

// Restoring unsigned divider, fully combinational. The carry bit holds the
// bit shifted out of the partial remainder. When it is set, the shifted value
// is >= 2^N > divisor, so a subtract is due, and the N-bit wrap-around
// difference is exact.
module divider_unsigned #(
  parameter int N = 32
) (
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  logic [N-1:0] part_rem;
  logic         carry;

  always_comb begin
    part_rem = '0;
    carry    = 1'b0;
    quotient = '0;
    for (int i = N - 1; i >= 0; i--) begin
      {carry, part_rem} = {part_rem, dividend[i]};
      if (carry || (part_rem >= divisor)) begin
        part_rem    = part_rem - divisor;
        quotient[i] = 1'b1;
      end
    end
    remainder = part_rem;
  end

endmodule

module div_seq_ctrl #(
  parameter int XLEN        = 32,
  parameter int WAIT_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      out_tag,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0]      CNT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [4:0]      tag_q, tag_d;
  logic [XLEN-1:0] mag_a_q, mag_a_d;
  logic [XLEN-1:0] mag_b_q, mag_b_d;
  // neg_quo: quotient needs negation (DIV only).
  // neg_rem: remainder needs negation (REM only).
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            signed_op;
  logic            is_rem;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            div_by_zero;
  logic            overflow;
  logic [XLEN-1:0] core_quo;
  logic [XLEN-1:0] core_rem;
  logic [XLEN-1:0] core_sel;
  logic            core_neg;

  // The core sees only registered magnitudes, so its inputs stay constant
  // for the whole settle window.
  divider_unsigned #(.N(XLEN)) u_core (
    .dividend  (mag_a_q),
    .divisor   (mag_b_q),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

  // Decode of the raw request. op[0]=0 means signed, and op[1]=1 means
  // remainder. The absolute value of INT_MIN wraps to itself, which is still
  // the right unsigned magnitude.
  always_comb begin
    signed_op   = ~op[0];
    is_rem      = op[1];
    abs_a       = (signed_op && rs1[XLEN-1]) ? -rs1 : rs1;
    abs_b       = (signed_op && rs2[XLEN-1]) ? -rs2 : rs2;
    div_by_zero = (rs2 == '0);
    overflow    = signed_op && (rs1 == INT_MIN) && (rs2 == '1);
  end

  // Choose the core output selected by the registered op and apply the
  // registered sign correction.
  always_comb begin
    core_sel = op_q[1] ? core_rem : core_quo;
    core_neg = op_q[1] ? neg_rem_q : neg_quo_q;
  end

  // Next-state logic. Flush wins over the accept and over the output
  // handshake. The payload registers keep their values on flush, and only
  // the state returns to IDLE.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tag_d     = tag_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_d      = op;
            tag_d     = in_tag;
            mag_a_d   = abs_a;
            mag_b_d   = abs_b;
            neg_quo_d = (op == 2'b00) && (rs1[XLEN-1] ^ rs2[XLEN-1]);
            neg_rem_d = (op == 2'b10) && rs1[XLEN-1];
            if (div_by_zero) begin
              result_d = is_rem ? rs1 : '1;
              state_d  = DONE;
            end else if (overflow) begin
              result_d = is_rem ? '0 : INT_MIN;
              state_d  = DONE;
`ifdef DIV_FAST_PATH_EN
            end else if (abs_b > abs_a) begin
              // A divisor larger than the dividend gives quotient 0 and
              // leaves the dividend as the remainder, including its sign.
              result_d = is_rem ? rs1 : '0;
              state_d  = DONE;
`endif
            end else begin
              cnt_d   = CNT_LOAD;
              state_d = CALC;
            end
          end
        end
        CALC: begin
          if (cnt_q == 4'd0) begin
            result_d = core_neg ? -core_sel : core_sel;
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and payload registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      tag_q     <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  // The handshake outputs are decoded from state alone, so no input has a
  // combinational path to them.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
    result    = result_q;
    out_tag   = tag_q;
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed scoreboard bench for div_seq_ctrl (XLEN=32, WAIT_CYCLES=4).
// Each request pushes its expected result, tag and latency. These entries
// are popped and compared when out_valid appears. Outputs are sampled on the
// falling edge.
module tb_div_seq_ctrl;

  localparam int XLEN = 32;
  localparam int WAIT = 4;

`ifdef DIV_FAST_PATH_EN
  localparam int FAST_LAT = 1;
`else
  localparam int FAST_LAT = WAIT + 1;
`endif

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
    string       name;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      op = 2'b00;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic [4:0]      in_tag = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic [4:0]      out_tag;
  logic            busy;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  div_seq_ctrl #(.XLEN(XLEN), .WAIT_CYCLES(WAIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  // Drive one request for one cycle. On return we are at the falling edge of
  // cycle 1, where cycle 0 is the accept cycle.
  task automatic driveAccept(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] t);
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    rs1      = a;
    rs2      = b;
    in_tag   = t;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input string name, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] t,
                               input logic [31:0] expRes, input int lat);
    exp_t e;
    e.res  = expRes;
    e.tag  = t;
    e.lat  = lat;
    e.name = name;
    sb.push_back(e);
    driveAccept(o, a, b, t);
  endtask

  // Wait (bounded) for out_valid, pop the scoreboard and compare. With
  // out_ready high, the handshake completes in this cycle and in_ready must
  // return in the next one.
  task automatic collectResult();
    exp_t e;
    int   cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      checkOutput({e.name, "_valid"}, 32'(out_valid), 32'd1);
      checkOutput({e.name, "_lat"}, 32'(cyc), 32'(e.lat));
      checkOutput({e.name, "_res"}, result, e.res);
      checkOutput({e.name, "_tag"}, 32'(out_tag), 32'(e.tag));
      if (out_ready) begin
        @(negedge clk);
        checkOutput({e.name, "_in_ready"}, 32'(in_ready), 32'd1);
      end
    end
  endtask

  initial begin
    // Reset state
    #12;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_out_tag", 32'(out_tag), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Normal path, unsigned
    applyStimulus("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd3, 32'd14, WAIT + 1);
    collectResult();
    applyStimulus("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd17, 32'd2, WAIT + 1);
    collectResult();

    // Signed sign correction
    applyStimulus("div_m7_2", 2'b00, -32'sd7, 32'd2, 5'd4, 32'hFFFF_FFFD, WAIT + 1);
    collectResult();
    applyStimulus("rem_m7_2", 2'b10, -32'sd7, 32'd2, 5'd5, 32'hFFFF_FFFF, WAIT + 1);
    collectResult();
    applyStimulus("rem_7_m2", 2'b10, 32'd7, -32'sd2, 5'd6, 32'd1, WAIT + 1);
    collectResult();
    applyStimulus("div_m8_m2", 2'b00, -32'sd8, -32'sd2, 5'd7, 32'd4, WAIT + 1);
    collectResult();

    // Divide-by-zero and overflow
    applyStimulus("divu_5_0", 2'b01, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1);
    collectResult();
    applyStimulus("rem_fb_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 5'd9, 32'hFFFF_FFFB, 1);
    collectResult();
    applyStimulus("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1);
    collectResult();
    applyStimulus("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 1);
    collectResult();

    // Fast-path candidate: the latency depends on the build option
    applyStimulus("divu_3_10", 2'b01, 32'd3, 32'd10, 5'd12, 32'd0, FAST_LAT);
    collectResult();

    // Backpressure: hold out_ready low for 3 cycles in DONE
    out_ready = 1'b0;
    applyStimulus("bp_divu", 2'b01, 32'd1000, 32'd9, 5'd21, 32'd111, WAIT + 1);
    collectResult();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_hold_res", result, 32'd111);
      checkOutput("bp_hold_tag", 32'(out_tag), 32'd21);
      checkOutput("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("bp_release_valid", 32'(out_valid), 32'd0);

    // Flush in cycle 2 of a normal operation
    driveAccept(2'b01, 32'd50, 32'd5, 5'd13);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_in_ready_c3", 32'(in_ready), 32'd1);
    begin
      logic seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      checkOutput("flush_no_valid", 32'(seen), 32'd0);
    end

    // Flush together with in_valid in IDLE: no accept
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    op       = 2'b01;
    rs1      = 32'd9;
    rs2      = 32'd0;
    in_tag   = 5'd30;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_idle_busy", 32'(busy), 32'd0);
    checkOutput("flush_idle_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    checkOutput("flush_idle_no_valid", 32'(out_valid), 32'd0);

    // Reset asserted mid-CALC
    driveAccept(2'b01, 32'd77, 32'd7, 5'd19);
    @(negedge clk);
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_result", result, 32'd0);
    checkOutput("midrst_out_tag", 32'(out_tag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      logic seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      checkOutput("midrst_no_valid", 32'(seen), 32'd0);
    end

    // The block must still work after the reset
    applyStimulus("post_rst_div", 2'b00, 32'd20, -32'sd3, 5'd25, 32'hFFFF_FFFA, WAIT + 1);
    collectResult();

    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
